// File: rtl/alu_seq_responder.sv
// Multicycle ALU responder: accepts op/x/y over a valid/ready request
// channel and returns z/err over a valid/ready response channel.
// Logic ops finish in one cycle. Shifts move one bit per cycle.
// MUL is a fixed-length shift-add multiply, one multiplier bit per cycle.
module alu_seq_responder #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             err
);

    localparam int CW = SHW + 1;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4;
    localparam logic [4:0] OP_NOT = 5'd5;
    localparam logic [4:0] OP_SLT = 5'd6;
    localparam logic [4:0] OP_SHL = 5'd7;
    localparam logic [4:0] OP_SHR = 5'd8;
    localparam logic [4:0] OP_SRA = 5'd9;
    localparam logic [4:0] OP_MUL = 5'd10;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [4:0]       op_r;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;

    logic [SHW-1:0]   shamt;
    logic             is_shift;
    logic             multi;
    logic             last_step;
    logic [WIDTH-1:0] quick_z;
    logic             quick_err;
    logic [WIDTH-1:0] step_work;

    assign shamt     = y[SHW-1:0];
    assign is_shift  = (alu_op == OP_SHL) || (alu_op == OP_SHR) || (alu_op == OP_SRA);
    assign multi     = (alu_op == OP_MUL) || (is_shift && (shamt != '0));
    assign last_step = (cnt == CW'(1));

    // Single-cycle result straight from the request inputs (zero-amount shifts pass x through)
    always_comb begin
        quick_z   = '0;
        quick_err = 1'b0;
        case (alu_op)
            OP_ADD: quick_z = x + y;
            OP_SUB: quick_z = x - y;
            OP_AND: quick_z = x & y;
            OP_OR:  quick_z = x | y;
            OP_XOR: quick_z = x ^ y;
            OP_NOT: quick_z = ~x;
            OP_SLT: quick_z = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_SHL, OP_SHR, OP_SRA: quick_z = x;
            OP_MUL: quick_z = '0;
            default: quick_err = 1'b1;
        endcase
    end

    // One iteration of the latched multicycle op applied to the working register
    always_comb begin
        step_work = work;
        case (op_r)
            OP_SHL:  step_work = {work[WIDTH-2:0], 1'b0};
            OP_SHR:  step_work = {1'b0, work[WIDTH-1:1]};
            OP_SRA:  step_work = {work[WIDTH-1], work[WIDTH-1:1]};
            OP_MUL:  step_work = mplier[0] ? (work + mcand) : work;
            default: step_work = work;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = multi ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latching, iterative datapath and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_r   <= '0;
            work   <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            z      <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_r <= alu_op;
                        if (alu_op == OP_MUL) begin
                            work   <= '0;
                            mcand  <= x;
                            mplier <= y;
                            cnt    <= CW'(WIDTH);
                        end else if (multi) begin
                            work <= x;
                            cnt  <= {1'b0, shamt};
                        end else begin
                            z   <= quick_z;
                            err <= quick_err;
                        end
                    end
                end
                BUSY: begin
                    work   <= step_work;
                    mcand  <= {mcand[WIDTH-2:0], 1'b0};
                    mplier <= {1'b0, mplier[WIDTH-1:1]};
                    cnt    <= cnt - CW'(1);
                    if (last_step) begin
                        z   <= step_work;
                        err <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_responder.sv
// Bench for alu_seq_responder: directed vector table, hand-written
// handshake/reset sequences, and random ops against a reference model.
module tb_alu_seq_responder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  alu_op;
    logic [15:0] x;
    logic [15:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] z;
    logic        err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [15:0] xv;
        logic [15:0] yv;
        logic [15:0] ez;
        logic        ee;
        int          elat;
    } vec_t;

    vec_t vq[$];

    alu_seq_responder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .err       (err)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: results from plain arithmetic, latency from the timing rules
    function automatic void ref_model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                                      output logic [15:0] r, output logic e, output int lat);
        int                 n;
        logic signed [15:0] sa;
        logic [31:0]        p;
        n   = int'(b % 16);
        sa  = a;
        e   = 1'b0;
        lat = 1;
        r   = '0;
        case (op)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a & b;
            5'd3:  r = a | b;
            5'd4:  r = a ^ b;
            5'd5:  r = ~a;
            5'd6:  r = (int'($signed(a)) < int'($signed(b))) ? 16'd1 : 16'd0;
            5'd7:  begin r = a << n;   lat = 1 + n; end
            5'd8:  begin r = a >> n;   lat = 1 + n; end
            5'd9:  begin r = sa >>> n; lat = 1 + n; end
            5'd10: begin p = 32'(a) * 32'(b); r = p[15:0]; lat = 17; end
            default: begin r = '0; e = 1'b1; end
        endcase
    endfunction

    // Issue one request, scramble inputs while busy, measure latency, then drain the response
    task automatic applyStimulus(input logic [4:0] op, input logic [15:0] xv, input logic [15:0] yv,
                                 output logic [15:0] zo, output logic eo, output int lat);
        int w;
        @(negedge clk);
        alu_op    = op;
        x         = xv;
        y         = yv;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) checkOutput("ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_op   = 5'($urandom);
        x        = 16'($urandom);
        y        = 16'($urandom);
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        zo = z;
        eo = err;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [15:0] zo;
        logic        eo;
        int          lat;
        applyStimulus(v.op, v.xv, v.yv, zo, eo, lat);
        checkOutput({v.name, "_z"}, 32'(zo), 32'(v.ez));
        checkOutput({v.name, "_err"}, 32'(eo), 32'(v.ee));
        checkOutput({v.name, "_lat"}, 32'(lat), 32'(v.elat));
    endtask

    initial begin
        logic [15:0] zo;
        logic        eo;
        int          lat;
        logic [15:0] mz;
        logic        me;
        int          mlat;
        logic [4:0]  rop;
        logic [15:0] rx;
        logic [15:0] ry;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_op    = '0;
        x         = '0;
        y         = '0;

        vq.push_back('{"add_3_4",     5'd0,  16'h0003, 16'h0004, 16'h0007, 1'b0, 1});
        vq.push_back('{"add_wrap",    5'd0,  16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1});
        vq.push_back('{"sub_wrap",    5'd1,  16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1});
        vq.push_back('{"slt_neg",     5'd6,  16'h8000, 16'h0001, 16'h0001, 1'b0, 1});
        vq.push_back('{"slt_pos",     5'd6,  16'h0001, 16'h8000, 16'h0000, 1'b0, 1});
        vq.push_back('{"or",          5'd3,  16'hF000, 16'h000F, 16'hF00F, 1'b0, 1});
        vq.push_back('{"xor",         5'd4,  16'hFF00, 16'h0FF0, 16'hF0F0, 1'b0, 1});
        vq.push_back('{"not",         5'd5,  16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1});
        vq.push_back('{"shl_15",      5'd7,  16'h0001, 16'h000F, 16'h8000, 1'b0, 16});
        vq.push_back('{"shl_hi_y",    5'd7,  16'h0011, 16'h0013, 16'h0088, 1'b0, 4});
        vq.push_back('{"sra_4",       5'd9,  16'h8000, 16'h0004, 16'hF800, 1'b0, 5});
        vq.push_back('{"sra_pos",     5'd9,  16'h7000, 16'h0001, 16'h3800, 1'b0, 2});
        vq.push_back('{"shr_0",       5'd8,  16'h8000, 16'h0000, 16'h8000, 1'b0, 1});
        vq.push_back('{"mul_ovf",     5'd10, 16'h0100, 16'h0100, 16'h0000, 1'b0, 17});
        vq.push_back('{"mul_3_5",     5'd10, 16'h0003, 16'h0005, 16'h000F, 1'b0, 17});
        vq.push_back('{"undef",       5'd31, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1});

        // Reset held for two edges
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_z", 32'(z), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD with out_ready high throughout: one DONE cycle, then IDLE again
        @(negedge clk);
        alu_op = 5'd0; x = 16'h0003; y = 16'h0004; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checkOutput("first_out_valid", 32'(out_valid), 32'd1);
        checkOutput("first_z", 32'(z), 32'h0007);
        checkOutput("first_err", 32'(err), 32'd0);
        checkOutput("first_in_ready_lo", 32'(in_ready), 32'd0);
        @(negedge clk);
        checkOutput("first_in_ready_hi", 32'(in_ready), 32'd1);
        checkOutput("first_out_valid_lo", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Directed table
        foreach (vq[i]) run_vec(vq[i]);

        // Backpressure: response held, extra requests ignored
        @(negedge clk);
        alu_op = 5'd0; x = 16'h1111; y = 16'h2222; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_z", 32'(z), 32'h3333);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            in_valid = i[0];
            alu_op   = 5'd1;
            x        = 16'h9999;
            y        = 16'h0001;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("bp_idle_ready", 32'(in_ready), 32'd1);
        checkOutput("bp_idle_valid", 32'(out_valid), 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("bp_no_queue", 32'(out_valid), 32'd0);

        // Reset during a MUL aborts it
        @(negedge clk);
        alu_op = 5'd10; x = 16'h0003; y = 16'h0005; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_z", 32'(z), 32'd0);
        rst_n = 1'b1;
        applyStimulus(5'd2, 16'h0F0F, 16'h00FF, zo, eo, lat);
        checkOutput("post_rst_and_z", 32'(zo), 32'h000F);
        checkOutput("post_rst_and_lat", 32'(lat), 32'd1);

        // Random ops against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = (i % 10 == 9) ? 5'd31 : 5'($urandom_range(0, 12));
            rx  = 16'($urandom);
            ry  = 16'($urandom);
            ref_model(rop, rx, ry, mz, me, mlat);
            applyStimulus(rop, rx, ry, zo, eo, lat);
            checkOutput($sformatf("rand%0d_op%0d_z", i, rop), 32'(zo), 32'(mz));
            checkOutput($sformatf("rand%0d_op%0d_err", i, rop), 32'(eo), 32'(me));
            checkOutput($sformatf("rand%0d_op%0d_lat", i, rop), 32'(lat), 32'(mlat));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
